// File: rtl/ps2_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_rx_pkg                                                |
// | Purpose  : Shared PS/2 receiver types and frame constants.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } PS2_RX_STATE;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                             input logic                     par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_sync_filter                                           |
// | Purpose  : Multi-flop synchronizer followed by a saturating glitch   |
// |            filter. The output level only changes after FILTER_LEN    |
// |            consecutive synchronized samples disagree with it.        |
// |            FILTER_LEN = 1 gives a plain synchronizer (+1 register).  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;

  // Synchronizer chain, idles high like the PS/2 bus.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  if (FILTER_LEN > 1) begin : g_filter
    localparam int                c_cnt_w   = $clog2(FILTER_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);
    logic [c_cnt_w-1:0] r_cnt;

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_level <= 1'b1;
        r_cnt   <= '0;
      end else if (w_sync == r_level) begin
        r_cnt   <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end else begin : g_no_filter
    // No filtering: just register the synchronized level.
    always_ff @(posedge clk) begin
      if (rst) r_level <= 1'b1;
      else     r_level <= w_sync;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_rx                                                    |
// | Purpose  : PS/2 device-to-host receiver. Synchronizes and filters    |
// |            the pins, deframes 11-bit frames and strobes out each     |
// |            good scan-code byte.                                      |
// | Options  : define PS2_PARITY_CHECK_EN to reject odd-parity failures  |
// |            with a parity_err strobe (otherwise parity is ignored).   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
import ps2_rx_pkg::*;

module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [PS2_DATA_BITS-1:0] ps2_pkt_DH,
  output logic                     rec_ps2_pkt,
  output logic                     frame_err,
  output logic                     parity_err
);

  localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam int                 c_bit_w    = $clog2(PS2_DATA_BITS);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(PS2_DATA_BITS - 1);

  PS2_RX_STATE              r_state, w_state_nxt;
  logic                     w_clk_lvl, w_data_lvl, r_clk_lvl_d;
  logic                     w_fall, w_expire, w_edge, w_par_ok;
  logic                     w_rec_nxt, w_ferr_nxt, w_perr_nxt;
  logic [c_bit_w-1:0]       r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic [c_tmo_w-1:0]       r_tmo;

  ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst_b), .i_pin(ps2_clk), .o_level(w_clk_lvl)
  );

  ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(1)) u_data_sync (
    .clk(clk), .rst(rst_b), .i_pin(ps2_data), .o_level(w_data_lvl)
  );

  // Timeout beats a coincident falling edge; that edge is simply dropped.
  assign w_fall   = r_clk_lvl_d & ~w_clk_lvl;
  assign w_expire = (r_state != IDLE) && (r_tmo == c_tmo_last);
  assign w_edge   = w_fall & ~w_expire;

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  assign w_par_ok = ps2_odd_parity_ok(r_shift, r_parity);

  // Capture the parity bit for the check made on the stop bit.
  always_ff @(posedge clk) begin
    if (rst_b)                            r_parity <= 1'b0;
    else if (w_edge && r_state == PARITY) r_parity <= w_data_lvl;
  end
`else
  assign w_par_ok = 1'b1;
`endif

  // Delayed filtered clock level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst_b) r_clk_lvl_d <= 1'b1;
    else       r_clk_lvl_d <= w_clk_lvl;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_b) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and strobe decode; at most one strobe is raised per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_rec_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
    if (w_expire) begin
      w_state_nxt = IDLE;
      w_ferr_nxt  = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE:   if (!w_data_lvl) w_state_nxt = DATA;
        DATA:   if (r_bit_cnt == c_bit_last) w_state_nxt = PARITY;
        PARITY: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          if (!w_data_lvl)    w_ferr_nxt = 1'b1;
          else if (!w_par_ok) w_perr_nxt = 1'b1;
          else                w_rec_nxt  = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Shift register, bit counter and inter-edge timeout counter.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tmo     <= '0;
    end else begin
      if (w_edge && r_state == IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_edge && r_state == DATA) begin
        r_shift   <= {w_data_lvl, r_shift[PS2_DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_state == IDLE || w_edge || w_expire) r_tmo <= '0;
      else if (r_tmo != c_tmo_last)              r_tmo <= r_tmo + 1'b1;
    end
  end

  // Registered outputs; the byte register only moves with its strobe.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      ps2_pkt_DH  <= '0;
      rec_ps2_pkt <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      rec_ps2_pkt <= w_rec_nxt;
      frame_err   <= w_ferr_nxt;
      parity_err  <= w_perr_nxt;
      if (w_rec_nxt) ps2_pkt_DH <= r_shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ps2_rx                                                 |
// | Purpose  : Self-checking bench for ps2_rx with a frame-level model.  |
// |            Honours PS2_PARITY_CHECK_EN in its expectations.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ps2_rx;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TMO  = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_pkt_DH;
  logic       rec_ps2_pkt, frame_err, parity_err;

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_fall_cyc = 0, last_rec_cyc = 0, last_ferr_cyc = 0;
  logic [7:0]  got_q[$];
  int          n_ferr = 0, n_perr = 0;
  logic [7:0]  exp_q[$];
  int          exp_ferr = 0, exp_perr = 0;
  logic [7:0]  exp_dh = 8'h00;
  logic        rst_q = 1'b1;
  logic [7:0]  prev_dh = 8'h00;

  ps2_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_b(rst_b), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_pkt_DH(ps2_pkt_DH), .rec_ps2_pkt(rec_ps2_pkt),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_b;
  end

  // Observe strobes and the hold behaviour of the byte output.
  always @(negedge clk) begin
    if (rec_ps2_pkt) begin
      got_q.push_back(ps2_pkt_DH);
      last_rec_cyc = cyc;
    end
    if (frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (parity_err) n_perr++;
    if (rec_ps2_pkt || frame_err || parity_err) begin
      n_assert++;
      if (int'(rec_ps2_pkt) + int'(frame_err) + int'(parity_err) != 1) begin
        n_fail++;
        $display("FAIL strobe_onehot: got rec=%0b ferr=%0b perr=%0b, required exactly one",
                 rec_ps2_pkt, frame_err, parity_err);
      end
    end
    if (!rst_q && ps2_pkt_DH !== prev_dh) begin
      n_assert++;
      if (!rec_ps2_pkt) begin
        n_fail++;
        $display("FAIL dh_hold: byte changed %h -> %h without rec_ps2_pkt", prev_dh, ps2_pkt_DH);
      end
    end
    prev_dh = ps2_pkt_DH;
  end

  // Frame-level reference model: what one complete frame should produce.
  task automatic expect_frame(input logic [7:0] d, input logic p, input logic s);
    bit par_bad;
    par_bad = ($countones({d, p}) % 2) == 0;
`ifndef PS2_PARITY_CHECK_EN
    par_bad = 1'b0;
`endif
    if (!s)           exp_ferr++;
    else if (par_bad) exp_perr++;
    else begin
      exp_q.push_back(d);
      exp_dh = d;
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    n_ferr = 0; n_perr = 0; exp_ferr = 0; exp_perr = 0;
  endtask

  // One device-driven bit: data set while clock high, then a low pulse.
  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge clk); ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_at, input int nbits);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == glitch_at);
    @(negedge clk); ps2_data = 1'b1;
    repeat (SYNC + FILT + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    n_assert++;
    if (ps2_pkt_DH !== 8'h00) begin
      n_fail++; $display("FAIL reset_dh: got %h required 00", ps2_pkt_DH);
    end
    n_assert++;
    if ({rec_ps2_pkt, frame_err, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 000", {rec_ps2_pkt, frame_err, parity_err});
    end
    exp_dh = 8'h00;
  endtask

  task automatic test_basic();
    clear_obs();
    expect_frame(8'h1C, 1'b0, 1'b1); send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
    n_assert++;
    if (int'(last_rec_cyc) - int'(last_fall_cyc) != SYNC + FILT + 1) begin
      n_fail++; $display("FAIL latency: got %0d cycles required %0d",
                         int'(last_rec_cyc) - int'(last_fall_cyc), SYNC + FILT + 1);
    end
    expect_frame(8'hF0, 1'b1, 1'b1); send_frame(8'hF0, 1'b1, 1'b1, -1, 11);
    expect_frame(8'h1C, 1'b0, 1'b1); send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
    n_assert++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_byte%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_parity();
    clear_obs();
    expect_frame(8'h1C, 1'b1, 1'b1); send_frame(8'h1C, 1'b1, 1'b1, -1, 11);
    n_assert++;
    if (n_perr != exp_perr || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL parity_events: got perr=%0d rec=%0d required perr=%0d rec=%0d",
                         n_perr, got_q.size(), exp_perr, exp_q.size());
    end
    n_assert++;
    if (ps2_pkt_DH !== exp_dh) begin
      n_fail++; $display("FAIL parity_dh: got %h required %h", ps2_pkt_DH, exp_dh);
    end
  endtask

  task automatic test_stop_err();
    clear_obs();
    expect_frame(8'h29, 1'b0, 1'b0); send_frame(8'h29, 1'b0, 1'b0, -1, 11);
    n_assert++;
    if (n_ferr != exp_ferr || got_q.size() != 0) begin
      n_fail++; $display("FAIL stop_err: got ferr=%0d rec=%0d required ferr=%0d rec=0",
                         n_ferr, got_q.size(), exp_ferr);
    end
    expect_frame(8'h29, 1'b0, 1'b1); send_frame(8'h29, 1'b0, 1'b1, -1, 11);
    n_assert++;
    if (got_q.size() != 1 || ps2_pkt_DH !== 8'h29) begin
      n_fail++; $display("FAIL stop_recover: got rec=%0d dh=%h required rec=1 dh=29", got_q.size(), ps2_pkt_DH);
    end
  endtask

  task automatic test_timeout();
    int budget;
    clear_obs();
    send_frame(8'hA5, 1'b0, 1'b1, -1, 5);
    budget = 0;
    while (n_ferr == 0 && budget < TMO + 200) begin
      @(negedge clk); budget++;
    end
    n_assert++;
    if (n_ferr != 1) begin
      n_fail++; $display("FAIL timeout_strobe: got %0d frame_err required 1", n_ferr);
    end
    n_assert++;
    if (int'(last_ferr_cyc) - int'(last_fall_cyc) != SYNC + FILT + 1 + TMO) begin
      n_fail++; $display("FAIL timeout_delay: got %0d cycles required %0d",
                         int'(last_ferr_cyc) - int'(last_fall_cyc), SYNC + FILT + 1 + TMO);
    end
    clear_obs();
    expect_frame(8'h5A, 1'b1, 1'b1); send_frame(8'h5A, 1'b1, 1'b1, -1, 11);
    n_assert++;
    if (got_q.size() != 1 || ps2_pkt_DH !== 8'h5A || n_ferr != 0) begin
      n_fail++; $display("FAIL timeout_recover: got rec=%0d dh=%h ferr=%0d required rec=1 dh=5a ferr=0",
                         got_q.size(), ps2_pkt_DH, n_ferr);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    expect_frame(8'h1C, 1'b0, 1'b1); send_frame(8'h1C, 1'b0, 1'b1, 3, 11);
    n_assert++;
    if (got_q.size() != 1 || ps2_pkt_DH !== 8'h1C || n_ferr != 0) begin
      n_fail++; $display("FAIL glitch: got rec=%0d dh=%h ferr=%0d required rec=1 dh=1c ferr=0",
                         got_q.size(), ps2_pkt_DH, n_ferr);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_frame(8'h76, 1'b0, 1'b1, -1, 5);
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0;
    exp_dh = 8'h00;
    n_assert++;
    if (ps2_pkt_DH !== 8'h00 || {rec_ps2_pkt, frame_err, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_outputs: got dh=%h strobes=%b required 00/000",
                         ps2_pkt_DH, {rec_ps2_pkt, frame_err, parity_err});
    end
    repeat (TMO + 50) @(negedge clk);
    n_assert++;
    if (n_ferr != 0 || n_perr != 0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_quiet: got ferr=%0d perr=%0d rec=%0d required 0/0/0",
                         n_ferr, n_perr, got_q.size());
    end
    expect_frame(8'h76, 1'b0, 1'b1); send_frame(8'h76, 1'b0, 1'b1, -1, 11);
    n_assert++;
    if (got_q.size() != 1 || ps2_pkt_DH !== 8'h76) begin
      n_fail++; $display("FAIL reset_mid_recover: got rec=%0d dh=%h required rec=1 dh=76", got_q.size(), ps2_pkt_DH);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p, s;
    clear_obs();
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      p = ~(^d);
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 5) != 0);
      expect_frame(d, p, s);
      send_frame(d, p, s, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : -1, 11);
    end
    n_assert++;
    if (got_q.size() != exp_q.size() || n_ferr != exp_ferr || n_perr != exp_perr) begin
      n_fail++; $display("FAIL random_counts: got rec=%0d ferr=%0d perr=%0d required rec=%0d ferr=%0d perr=%0d",
                         got_q.size(), n_ferr, n_perr, exp_q.size(), exp_ferr, exp_perr);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random_byte%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_assert++;
    if (ps2_pkt_DH !== exp_dh) begin
      n_fail++; $display("FAIL random_dh: got %h required %h", ps2_pkt_DH, exp_dh);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver feeding `ps2_parse`. It samples the asynchronous `ps2_clk`/`ps2_data` pins, synchronizes them to `clk`, and de-glitches the PS/2 clock. It deframes 11-bit device-to-host frames and presents each good scan-code byte as `ps2_pkt_DH` with a one-cycle `rec_ps2_pkt` strobe. It replaces the constant tie-off of those two signals in the Game of Life top level.

## Interface
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on both pins (min 2).
- `FILTER_LEN`, 4: consecutive identical synchronized `ps2_clk` samples needed to change the filtered level (min 1).
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a filtered falling edge before a partial frame is abandoned.
- `clk` input 1: system clock.
- `rst_b` input 1: synchronous, active-high reset (1 = reset).
- `ps2_clk` input 1: PS/2 clock pin, asynchronous.
- `ps2_data` input 1: PS/2 data pin, asynchronous.
- `ps2_pkt_DH` output 8: last good received byte; holds until the next good frame.
- `rec_ps2_pkt` output 1: one-cycle strobe; `ps2_pkt_DH` is valid in the same cycle.
- `frame_err` output 1: one-cycle strobe on a bad stop bit or a timeout.
- `parity_err` output 1: one-cycle strobe on odd-parity failure. Tied 0 when parity checking is compiled out.

## Operation
- Both pins pass through `SYNC_STAGES` flip-flops.
- The synchronized `ps2_clk` feeds a saturating glitch filter. The filtered level resets to 1.
- A falling edge is filtered level 1→0 between consecutive cycles. On that cycle the synchronized `ps2_data` is sampled as bit `b`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: if `b`=0 (start bit), clear the bit counter and go to DATA. If `b`=1, stay in IDLE with no error.
  - DATA: shift `b` in LSB-first. After the 8th bit go to PARITY.
  - PARITY: store `b`, go to STOP.
  - STOP: go to IDLE. If `b`=0, pulse `frame_err`. Otherwise run the parity check (see Configuration). On pass, load `ps2_pkt_DH` and pulse `rec_ps2_pkt`.
- Parity rule: XOR of the 8 data bits plus the parity bit must equal 1 (odd parity).
- Timeout counter:
  - Counts `clk` cycles while not in IDLE.
  - Clears on every filtered falling edge.
  - At `TIMEOUT_CYCLES`: FSM goes to IDLE, `frame_err` pulses, the partial byte is discarded.
  - The counter is wide enough for `TIMEOUT_CYCLES` and saturates.
- Simultaneous events: a falling edge in the same cycle the timeout expires is ignored (timeout wins). The next falling edge is treated as in IDLE.
- At most one of `rec_ps2_pkt`, `frame_err`, `parity_err` is high in any cycle.
- The block never drives the PS/2 pins; host-to-device traffic is out of scope.

## Timing
- Reset values:
  - all synchronizer flops = 1; filtered level = 1; filter count = 0;
  - FSM = IDLE; bit counter = 0; timeout counter = 0;
  - `ps2_pkt_DH` = 8'h00; `rec_ps2_pkt`, `frame_err`, `parity_err` = 0.
- Reset mid-frame drops the partial frame with no error strobe. The first frame after reset release needs a full start bit.
- Latency: a stable pin-level fall of `ps2_clk` (stop bit) produces `rec_ps2_pkt` exactly `SYNC_STAGES + FILTER_LEN + 1` cycles later.
- All outputs are registered.
- `ps2_pkt_DH` changes only in the cycle `rec_ps2_pkt` is high.
- Any `ps2_clk` pulse of fewer than `FILTER_LEN` cycles (after synchronization) does not change the filtered level.
- Consumers need no handshake. A strobe is never stretched or repeated.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - failing parity in STOP pulses `parity_err`;
  - no `rec_ps2_pkt`;
  - `ps2_pkt_DH` unchanged.
- `PS2_PARITY_CHECK_EN` undefined:
  - the parity bit is consumed but ignored;
  - every frame with stop=1 is delivered;
  - `parity_err` is constant 0.

## Structure
- Shared package, next to `KEYS`/`CTRL_CMDS`:
  - enum `PS2_RX_STATE` (IDLE, DATA, PARITY, STOP);
  - constant `PS2_FRAME_BITS` = 11;
  - constant `PS2_DATA_BITS` = 8.
- Sub-module `ps2_sync_filter`, parameterized by `SYNC_STAGES` and `FILTER_LEN`:
  - instance on `ps2_clk` with filtering, outputs the filtered level;
  - instance on `ps2_data` with `FILTER_LEN`=1 (synchronizer only).
- Edge detect, FSM, shift register, timeout and output registers live in `ps2_rx`.

## Test plan
- Frame for 8'h1C: start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1; ~60 µs clock period → one `rec_ps2_pkt` with `ps2_pkt_DH`=8'h1C. Then frames 8'hF0 (parity 1) and 8'h1C → two more strobes with those values.
- 8'h1C sent with parity 1, macro defined → `parity_err` pulse, no `rec_ps2_pkt`, `ps2_pkt_DH` holds the previous value. Same stimulus with macro undefined → `rec_ps2_pkt` with 8'h1C.
- 8'h29 with stop bit 0 → `frame_err` pulse, no strobe. Next valid 8'h29 → strobe with 8'h29.
- `TIMEOUT_CYCLES`=1000; 5 bits sent, then the clock idles high → `frame_err` exactly 1000 cycles after the last falling edge. Next full 8'h5A frame → strobe with 8'h5A.
- `FILTER_LEN`=4; a 2-cycle low glitch on `ps2_clk` inside a DATA bit of 8'h1C → glitch ignored, 8'h1C received.
- `rst_b` asserted for one cycle after the 4th data bit → all outputs at reset values, no strobes. Next full 8'h76 frame → strobe with 8'h76.
